elevator_car_drive: RTL and testbench
=====================================

ELEVATOR_CAR_DRIVE -- requirements
Module: elevator_car_drive

Interface
REQ-001 SHALL have parameter TRAVEL_CYCLES, default 16, cycles spent moving between floors (range 1..255).
REQ-002 SHALL have parameter DOOR_CYCLES, default 8, cycles the door stays open per arrival (range 1..255).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  controller presents a floor request.
REQ-007 cmd_floor  input  1  requested floor: 0 = floor 1, 1 = floor 2.
REQ-008 cmd_ready  output  1  car idle at a floor, door closed, able to accept a request.
REQ-009 hold  input  1  door-hold button; extends the door-open time.
REQ-010 floor_1  output  1  car parked at floor 1.
REQ-011 floor_2  output  1  car parked at floor 2.
REQ-012 motor_up  output  1  hoist motor driving up.
REQ-013 motor_down  output  1  hoist motor driving down.
REQ-014 door_open  output  1  door open command.
REQ-015 arrived  output  1  single-cycle pulse on arrival, including a same-floor request.

Function
REQ-016 SHALL implement four states: IDLE, MOVING_UP, MOVING_DOWN, DOOR_OPEN.
REQ-017 SHALL drive cmd_ready high only in IDLE.
REQ-018 SHALL accept a request at an edge where cmd_valid and cmd_ready are both high, and SHALL ignore cmd_valid in all other states.
REQ-019 On accepting a request for the other floor, SHALL move to MOVING_UP (from floor 1) or MOVING_DOWN (from floor 2) and load the timer with TRAVEL_CYCLES-1.
REQ-020 On accepting a request for the current floor, SHALL move directly to DOOR_OPEN without driving the motor.
REQ-021 SHALL keep motor_up or motor_down high for exactly TRAVEL_CYCLES cycles, and SHALL hold floor_1 and floor_2 low throughout.
REQ-022 SHALL ignore hold while moving; travel SHALL NOT be interrupted.
REQ-023 When the travel timer reaches 0, SHALL enter DOOR_OPEN at the next edge, set the floor output for the destination, and pulse arrived for that first DOOR_OPEN cycle only.
REQ-024 On entering DOOR_OPEN, SHALL load the timer with DOOR_CYCLES-1 and decrement it once per cycle.
REQ-025 A cycle in DOOR_OPEN with hold high SHALL reload the timer with DOOR_CYCLES-1.
REQ-026 SHALL leave DOOR_OPEN for IDLE at the first edge where the timer is 0 and hold is low; absent hold, door_open SHALL be high for exactly DOOR_CYCLES cycles.
REQ-027 floor_1 and floor_2 SHALL be mutually exclusive, with exactly one high in IDLE and in DOOR_OPEN.
REQ-028 motor_up, motor_down and door_open SHALL be mutually exclusive and SHALL come directly from registers (no combinational path from inputs).
REQ-029 An illegal state encoding SHALL recover to IDLE at floor 1 on the next edge.

Reset
REQ-030 Reset SHALL force IDLE, floor 1, and timer 0 at the next edge.
REQ-031 After reset, SHALL present: floor_1=1, floor_2=0, motor_up=0, motor_down=0, door_open=0, arrived=0, cmd_ready=1.
REQ-032 Reset mid-travel or with the door open SHALL abandon the operation without an arrived pulse.
REQ-033 cmd_valid SHALL be ignored in any cycle where reset is high.

Structure
REQ-034 Package elevator_pkg SHALL hold the state enum, floor encoding constants (FLOOR_1=0, FLOOR_2=1), and the default TRAVEL_CYCLES/DOOR_CYCLES values.
REQ-035 The timer SHALL be a sub-module elevator_timer: 8-bit loadable down-counter with load, value and zero flag, saturating at 0.

Verification (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-036 Reset, then cmd_valid=1, cmd_floor=1 for 1 cycle -> motor_up high for 4 cycles with floor outputs 0; then floor_2=1, arrived pulses 1 cycle, door_open high 3 cycles; cmd_ready returns 7 cycles after the accept edge.
REQ-037 At floor 2, request cmd_floor=1 -> no motor activity; door_open high for 3 cycles; arrived pulses once.
REQ-038 During DOOR_OPEN, hold high for 5 consecutive cycles -> door_open stays high until 3 cycles after hold falls.
REQ-039 Hold cmd_valid high continuously while moving, alternating cmd_floor -> exactly one request accepted per IDLE visit; hold while moving has no effect.
REQ-040 Assert reset on the 2nd MOVING_DOWN cycle -> next cycle floor_1=1, motors 0, arrived never pulses, cmd_ready=1.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the two-floor elevator car drive.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        MOVING_UP   = 2'd1,
        MOVING_DOWN = 2'd2,
        DOOR_OPEN   = 2'd3
    } state_t;

    localparam logic FLOOR_1 = 1'b0;
    localparam logic FLOOR_2 = 1'b1;

    localparam int unsigned DEFAULT_TRAVEL_CYCLES = 16;
    localparam int unsigned DEFAULT_DOOR_CYCLES   = 8;

endpackage

// File: rtl/elevator_timer.sv
// 8-bit loadable down-counter that saturates at zero.
module elevator_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [7:0] value,
    output logic       zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= 8'd0;
        end else if (load) begin
            value <= load_value;
        end else if (value != 8'd0) begin
            value <= value - 8'd1;
        end
    end

    assign zero = (value == 8'd0);

endmodule

// File: rtl/elevator_car_drive.sv
// Two-floor elevator car sequencer: travel timing, door dwell with hold, arrival pulse.
// state       | meaning
// IDLE        | parked, door closed, accepting requests
// MOVING_UP   | motor driving from floor 1 to floor 2
// MOVING_DOWN | motor driving from floor 2 to floor 1
// DOOR_OPEN   | parked with door open, dwell timer running
module elevator_car_drive
    import elevator_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = DEFAULT_TRAVEL_CYCLES,
    parameter int unsigned DOOR_CYCLES   = DEFAULT_DOOR_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_valid,
    input  logic cmd_floor,
    output logic cmd_ready,
    input  logic hold,
    output logic floor_1,
    output logic floor_2,
    output logic motor_up,
    output logic motor_down,
    output logic door_open,
    output logic arrived
);

    localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

    state_t     state;
    logic       floor_pos;
    logic       timer_load;
    logic [7:0] timer_load_value;
    logic [7:0] timer_value;
    logic       timer_zero;

    elevator_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_load_value),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    always_comb begin
        timer_load       = 1'b0;
        timer_load_value = DOOR_LOAD;
        case (state)
            IDLE: begin
                timer_load = cmd_valid;
                if (cmd_floor != floor_pos) timer_load_value = TRAVEL_LOAD;
            end
            MOVING_UP, MOVING_DOWN: timer_load = timer_zero;
            DOOR_OPEN:              timer_load = hold;
            default:                timer_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            floor_pos  <= FLOOR_1;
            floor_1    <= 1'b1;
            floor_2    <= 1'b0;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            door_open  <= 1'b0;
            arrived    <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            arrived <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (cmd_floor == floor_pos) begin
                            state     <= DOOR_OPEN;
                            door_open <= 1'b1;
                            arrived   <= 1'b1;
                        end else begin
                            floor_1 <= 1'b0;
                            floor_2 <= 1'b0;
                            if (floor_pos == FLOOR_1) begin
                                state    <= MOVING_UP;
                                motor_up <= 1'b1;
                            end else begin
                                state      <= MOVING_DOWN;
                                motor_down <= 1'b1;
                            end
                        end
                    end
                end
                MOVING_UP: begin
                    if (timer_zero) begin
                        state     <= DOOR_OPEN;
                        motor_up  <= 1'b0;
                        door_open <= 1'b1;
                        arrived   <= 1'b1;
                        floor_pos <= FLOOR_2;
                        floor_2   <= 1'b1;
                    end
                end
                MOVING_DOWN: begin
                    if (timer_zero) begin
                        state      <= DOOR_OPEN;
                        motor_down <= 1'b0;
                        door_open  <= 1'b1;
                        arrived    <= 1'b1;
                        floor_pos  <= FLOOR_1;
                        floor_1    <= 1'b1;
                    end
                end
                DOOR_OPEN: begin
                    // hold takes priority: the timer reloads instead of letting the door close
                    if (timer_value == 8'd0 && !hold) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    floor_pos  <= FLOOR_1;
                    floor_1    <= 1'b1;
                    floor_2    <= 1'b0;
                    motor_up   <= 1'b0;
                    motor_down <= 1'b0;
                    door_open  <= 1'b0;
                    cmd_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_car_drive.sv
// Directed scoreboard bench for elevator_car_drive with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
module tb_elevator_car_drive;

    logic clk = 1'b0;
    logic reset, cmd_valid, cmd_floor, hold;
    logic cmd_ready, floor_1, floor_2, motor_up, motor_down, door_open, arrived;

    typedef struct {
        string      tag;
        logic [6:0] vec;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // {cmd_ready, floor_1, floor_2, motor_up, motor_down, door_open, arrived}
    localparam logic [6:0] V_IDLE1  = 7'b1100000;
    localparam logic [6:0] V_IDLE2  = 7'b1010000;
    localparam logic [6:0] V_UP     = 7'b0001000;
    localparam logic [6:0] V_DN     = 7'b0000100;
    localparam logic [6:0] V_DOOR1  = 7'b0100010;
    localparam logic [6:0] V_DOOR1A = 7'b0100011;
    localparam logic [6:0] V_DOOR2  = 7'b0010010;
    localparam logic [6:0] V_DOOR2A = 7'b0010011;

    elevator_car_drive #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_floor  (cmd_floor),
        .cmd_ready  (cmd_ready),
        .hold       (hold),
        .floor_1    (floor_1),
        .floor_2    (floor_2),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .door_open  (door_open),
        .arrived    (arrived)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [6:0] v, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag = tag;
            e.vec = v;
            sb.push_back(e);
        end
    endtask

    task automatic check();
        exp_t       e;
        logic [6:0] obs;
        obs = {cmd_ready, floor_1, floor_2, motor_up, motor_down, door_open, arrived};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%b expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.vec) else begin
                bad++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.vec);
            end
        end
    endtask

    task automatic step(input logic v, input logic f, input logic h, input logic r);
        cmd_valid = v;
        cmd_floor = f;
        hold      = h;
        reset     = r;
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_floor = 1'b0; hold = 1'b0;

        push("reset_state", V_IDLE1, 1);
        step(0, 0, 0, 1);

        // trip up: 4 motor cycles, arrival pulse, 3 door cycles, ready 7 cycles after accept
        push("travel_up", V_UP, 4);
        push("arrive_f2", V_DOOR2A, 1);
        push("door_f2", V_DOOR2, 2);
        push("ready_f2", V_IDLE2, 1);
        step(1, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0);

        // same-floor request: no motor, door straight away
        push("same_floor_arrive", V_DOOR2A, 1);
        push("same_floor_door", V_DOOR2, 2);
        push("same_floor_ready", V_IDLE2, 1);
        step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // hold for 5 cycles keeps the door open for 3 cycles past its release
        push("hold_arrive", V_DOOR2A, 1);
        push("hold_door", V_DOOR2, 5);
        push("hold_release", V_DOOR2, 2);
        push("hold_ready", V_IDLE2, 1);
        step(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // cmd_valid held high throughout; floor flips after each accept; hold while moving
        push("stream_down", V_DN, 4);
        push("stream_arrive_f1", V_DOOR1A, 1);
        push("stream_door_f1", V_DOOR1, 2);
        push("stream_ready_f1", V_IDLE1, 1);
        push("stream_up", V_UP, 4);
        push("stream_arrive_f2", V_DOOR2A, 1);
        push("stream_door_f2", V_DOOR2, 2);
        push("stream_ready_f2", V_IDLE2, 1);
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

        // reset on the 2nd MOVING_DOWN cycle abandons the trip with no arrival
        push("abort_down_1", V_DN, 2);
        push("abort_reset", V_IDLE1, 1);
        push("abort_quiet", V_IDLE1, 5);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

        // reset with the door open, with cmd_valid high during reset
        push("door_before_reset", V_DOOR1A, 1);
        push("reset_in_door", V_IDLE1, 1);
        push("valid_during_reset", V_IDLE1, 1);
        push("after_reset_quiet", V_IDLE1, 2);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(1, 1, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
